// File: rtl/ahb_lite_slave_if.sv
// ahb_lite_slave_if: AHB-Lite slave front-end turning pipelined transfers into a valid/ready back-end request
// with local address/alignment/size/timeout checks and the two-cycle ERROR response.
module ahb_lite_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_SPAN  = 4096,
    parameter int TIMEOUT    = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADYIN,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    req_valid,
    output logic                    req_write,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH/8-1:0] req_strb,
    output logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   rsp_rdata,
    input  logic                    rsp_error
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_t;

    state_t                  state_q, state_d, nxt_cap;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, amask;
    logic                    write_q, write_d;
    logic [NB-1:0]           strb_q, strb_d, cap_strb;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    capture, lerr, done, waiting, tout;
    int                      lane;
    logic                    unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};
    assign capture   = HSEL & HREADYIN & HTRANS[1];

    always_comb begin
        amask = ~({ADDR_WIDTH{1'b1}} << HSIZE);
        lane  = int'(HADDR & ADDR_WIDTH'(NB - 1));
        lerr  = (HADDR >= ADDR_WIDTH'(ADDR_SPAN)) | (|(HADDR & amask)) | (int'(HSIZE) > LW);
        for (int i = 0; i < NB; i++)
            cap_strb[i] = (i >= lane) && (i < lane + (1 << HSIZE));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter clears whenever the slave is not sitting in a wait cycle, so every ACCESS entry starts at 0.
    always_comb begin
        done    = (state_q == S_ACCESS) & req_ready;
        waiting = (state_q == S_ACCESS) & ~req_ready;
        tout    = (TIMEOUT != 0) & waiting & (cnt_q == TMAX - 1'b1);
        nxt_cap = capture ? (lerr ? S_ERR1 : S_ACCESS) : S_IDLE;
        state_d = (state_q == S_IDLE || state_q == S_ERR2) ? nxt_cap :
                  (state_q == S_ERR1) ? S_ERR2 :
                  done ? (rsp_error ? S_ERR1 : nxt_cap) :
                  tout ? S_ERR1 : S_ACCESS;
        cnt_d   = !waiting ? '0 : (cnt_q != TMAX) ? cnt_q + 1'b1 : cnt_q;
        addr_d  = capture ? HADDR : addr_q;
        write_d = capture ? HWRITE : write_q;
        strb_d  = capture ? cap_strb : strb_q;
    end

    always_comb begin
        req_valid = state_q == S_ACCESS;
        HRESP     = (state_q == S_ERR1) | (state_q == S_ERR2);
        HREADYOUT = (state_q == S_IDLE) | (state_q == S_ERR2) | (done & ~rsp_error);
        HRDATA    = (done & ~rsp_error & ~write_q) ? rsp_rdata : '0;
    end

    assign req_write = write_q;
    assign req_addr  = addr_q;
    assign req_strb  = strb_q;
    assign req_wdata = HWDATA;
endmodule

// File: tb/tb_ahb_lite_slave_if.sv
// tb_ahb_lite_slave_if: directed vectors with hand-computed expectations for the AHB-Lite slave front-end.
module tb_ahb_lite_slave_if;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = T_IDLE;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = '0;
    logic [31:0] HWDATA = '0;
    logic        HREADYIN;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP;
    logic        req_valid, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic        req_ready = 1'b0;
    logic [31:0] rsp_rdata = '0;
    logic        rsp_error = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: the mux returns our own HREADYOUT.
    assign HREADYIN = HREADYOUT;

    ahb_lite_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ADDR_SPAN(4096), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HWDATA(HWDATA),
        .HREADYIN(HREADYIN), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_strb(req_strb),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: inputs change on the falling edge, outputs are checked 2 ns later.
    task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic rdy, input logic er,
                       input logic [31:0] rd);
        @(negedge HCLK);
        HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a;
        HWDATA = wd; req_ready = rdy; rsp_error = er; rsp_rdata = rd;
        #2;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, rdy, 1'b0, 32'h0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hready"}, {31'b0, HREADYOUT}, 32'd1);
        chk({tag, "_hresp"}, {31'b0, HRESP}, 32'd0);
        chk({tag, "_hrdata"}, HRDATA, 32'h0);
        chk({tag, "_valid"}, {31'b0, req_valid}, 32'd0);
        chk({tag, "_write"}, {31'b0, req_write}, 32'd0);
        chk({tag, "_addr"}, req_addr, 32'h0);
        chk({tag, "_strb"}, {28'b0, req_strb}, 32'h0);
    endtask

    logic        b_sel  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  b_tr   [8] = '{T_NS, T_SEQ, T_BUSY, T_NS, T_IDLE, T_NS, T_NS, T_IDLE};
    logic [31:0] b_addr [8] = '{32'h40, 32'h44, 32'h44, 32'h48, 32'h0, 32'h80, 32'h4C, 32'h0};

    initial begin
        logic        pv;
        logic [31:0] pa;
        int          nreq;
        #3;
        chk_reset("rst");
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Zero-wait word write
        cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("w_addrph_valid", {31'b0, req_valid}, 32'd0);
        cyc(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h12345678, 1'b1, 1'b0, 32'h0);
        chk("w_valid", {31'b0, req_valid}, 32'd1);
        chk("w_write", {31'b0, req_write}, 32'd1);
        chk("w_addr", req_addr, 32'h10);
        chk("w_strb", {28'b0, req_strb}, 32'hF);
        chk("w_wdata", req_wdata, 32'h12345678);
        chk("w_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("w_hresp", {31'b0, HRESP}, 32'd0);
        idle(1'b0);
        chk("w_after_valid", {31'b0, req_valid}, 32'd0);

        // Byte read with 3 wait states
        cyc(1'b1, T_NS, 1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("r_wait_hready", {31'b0, HREADYOUT}, 32'd0);
            chk("r_wait_valid", {31'b0, req_valid}, 32'd1);
            chk("r_wait_strb", {28'b0, req_strb}, 32'h8);
            chk("r_wait_addr", req_addr, 32'h13);
            chk("r_wait_hrdata", HRDATA, 32'h0);
        end
        cyc(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hAABBCCDD);
        chk("r_done_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("r_done_hrdata", HRDATA, 32'hAABBCCDD);
        idle(1'b0);
        chk("r_after_hrdata", HRDATA, 32'h0);

        // Local errors: misaligned halfword, then address at span
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, T_NS, 1'b0, k == 0 ? 3'd1 : 3'd2, k == 0 ? 32'h11 : 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0);
            idle(1'b1);
            chk("le_e1_valid", {31'b0, req_valid}, 32'd0);
            chk("le_e1_hresp", {31'b0, HRESP}, 32'd1);
            chk("le_e1_hready", {31'b0, HREADYOUT}, 32'd0);
            idle(1'b1);
            chk("le_e2_valid", {31'b0, req_valid}, 32'd0);
            chk("le_e2_hresp", {31'b0, HRESP}, 32'd1);
            chk("le_e2_hready", {31'b0, HREADYOUT}, 32'd1);
            idle(1'b1);
            chk("le_end_hresp", {31'b0, HRESP}, 32'd0);
        end

        // Back-end error, then a NONSEQ issued during ERR2
        cyc(1'b1, T_NS, 1'b1, 3'd2, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("be_acc_hready", {31'b0, HREADYOUT}, 32'd0);
        chk("be_acc_hresp", {31'b0, HRESP}, 32'd0);
        idle(1'b0);
        chk("be_e1_hresp", {31'b0, HRESP}, 32'd1);
        chk("be_e1_hready", {31'b0, HREADYOUT}, 32'd0);
        chk("be_e1_valid", {31'b0, req_valid}, 32'd0);
        cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("be_e2_hresp", {31'b0, HRESP}, 32'd1);
        chk("be_e2_hready", {31'b0, HREADYOUT}, 32'd1);
        cyc(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h55);
        chk("be_next_hready", {31'b0, HREADYOUT}, 32'd1);
        chk("be_next_hresp", {31'b0, HRESP}, 32'd0);
        chk("be_next_addr", req_addr, 32'h24);
        chk("be_next_hrdata", HRDATA, 32'h55);

        // Timeout after 4 wait cycles
        cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("to_wait_valid", {31'b0, req_valid}, 32'd1);
            chk("to_wait_hready", {31'b0, HREADYOUT}, 32'd0);
        end
        idle(1'b0);
        chk("to_e1_valid", {31'b0, req_valid}, 32'd0);
        chk("to_e1_hresp", {31'b0, HRESP}, 32'd1);
        chk("to_e1_hready", {31'b0, HREADYOUT}, 32'd0);
        idle(1'b0);
        chk("to_e2_hresp", {31'b0, HRESP}, 32'd1);
        chk("to_e2_hready", {31'b0, HREADYOUT}, 32'd1);
        idle(1'b0);
        chk("to_end_hresp", {31'b0, HRESP}, 32'd0);

        // Back-to-back writes mixed with BUSY, IDLE and deselected cycles
        pv = 1'b0; pa = '0; nreq = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) cyc(b_sel[i], b_tr[i], 1'b1, 3'd2, b_addr[i], 32'h0, 1'b1, 1'b0, 32'h0);
            else idle(1'b1);
            chk("b2b_valid", {31'b0, req_valid}, {31'b0, pv});
            if (pv) begin
                chk("b2b_addr", req_addr, pa);
                chk("b2b_hready", {31'b0, HREADYOUT}, 32'd1);
            end
            if (req_valid) nreq++;
            pv = (i < 8) && b_sel[i] && b_tr[i][1];
            pa = (i < 8) ? b_addr[i] : 32'h0;
        end
        chk("b2b_count", nreq, 32'd4);

        // Asynchronous reset in the middle of a wait
        cyc(1'b1, T_NS, 1'b0, 3'd2, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        chk("ar_pre_valid", {31'b0, req_valid}, 32'd1);
        #1 HRESETn = 1'b0;
        #1 chk_reset("ar");
        @(negedge HCLK);
        HRESETn = 1'b1;
        idle(1'b0);
        chk("ar_after_valid", {31'b0, req_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
